// File: rtl/dek_pkg.sv
// Shared types and helpers for the dekatron counter.
// One-hot digit ring type plus BCD/one-hot conversions.
package dek_pkg;

  typedef logic [9:0] dek_oh_t;

  localparam dek_oh_t DEK_ZERO = 10'b00_0000_0001;
  localparam dek_oh_t DEK_NINE = 10'b10_0000_0000;

  // BCD digit to one-hot; codes above 9 map to 9
  function automatic dek_oh_t dek_bcd2oh(
    input logic [3:0] b
  );
    dek_oh_t r;
    r = '0;
    if (b > 4'd9) r = DEK_NINE;
    else r[b] = 1'b1;
    return r;
  endfunction

  // One-hot digit to BCD
  function automatic logic [3:0] dek_oh2bcd(
    input dek_oh_t oh
  );
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 10; i++)
      if (oh[i]) r = r | 4'(i);
    return r;
  endfunction

  // Integer limit split into packed BCD digits
  function automatic logic [23:0] dek_max_bcd(
    input int unsigned v
  );
    logic [23:0] r;
    int unsigned t;
    r = '0;
    t = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/dek_digit.sv
// One dekatron digit: a 10-position one-hot ring.
// Steps either way, loads, and flags the roll corner.
module dek_digit
  import dek_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_load,
  input  dek_oh_t i_load_oh,
  input  logic    i_step,
  input  logic    i_rev,
  output dek_oh_t o_oh,
  output logic    o_corner
);

  dek_oh_t r_oh;

  // Ring state: load wins over a step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_oh <= DEK_ZERO;
    end else if (i_load) begin
      r_oh <= i_load_oh;
    end else if (i_step) begin
      if (i_rev) r_oh <= {r_oh[0], r_oh[9:1]};
      else       r_oh <= {r_oh[8:0], r_oh[9]};
    end
  end

  assign o_oh     = r_oh;
  assign o_corner = i_rev ? r_oh[0] : r_oh[9];

endmodule

// File: rtl/dekatron_counter.sv
// Multi-digit dekatron up/down counter with
// optional digit-serial carry ripple.
module dekatron_counter
  import dek_pkg::*;
#(
  parameter int DIGITS    = 3,
  parameter int MAX_VALUE = 255,
  parameter int WRAP_MODE = 1,
  parameter int RIPPLE    = 0
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                Step,
  input  logic                Reverse,
  input  logic                Set,
  input  logic [4*DIGITS-1:0] In,
  output logic [4*DIGITS-1:0] Out,
  output logic [10*DIGITS-1:0] OutOneHot,
  output logic                Busy,
  output logic                Limit,
  output logic                Zero,
  output logic                AtMax
);

  localparam int W = 4 * DIGITS;
  localparam logic [23:0] MAX24 = dek_max_bcd(MAX_VALUE);
  localparam logic [W-1:0] MAX_BCD = MAX24[W-1:0];

  logic [W-1:0]      w_in_sat;
  logic [W-1:0]      w_set_bcd;
  logic [W-1:0]      w_load_bcd;
  logic              w_accept;
  logic              w_limit;
  logic              w_load;
  logic [DIGITS:0]   w_carry;
  logic [DIGITS-1:0] w_carry_nxt;
  logic [DIGITS-1:0] w_step;
  logic [DIGITS-1:0] w_dir;
  logic [DIGITS-1:0] w_corner;
  dek_oh_t           w_oh [DIGITS];
  dek_oh_t           w_load_oh [DIGITS];

  logic [DIGITS-1:0] r_carry;
  logic              r_rev;
  logic              r_limit;

  // Load value: saturate bad digits, then clamp
  always_comb begin
    w_in_sat = In;
    for (int k = 0; k < DIGITS; k++)
      if (In[4*k +: 4] > 4'd9)
        w_in_sat[4*k +: 4] = 4'd9;
    w_set_bcd = (w_in_sat > MAX_BCD) ? MAX_BCD
                                     : w_in_sat;
  end

  assign Busy     = |r_carry;
  assign Zero     = (Out == '0);
  assign AtMax    = (Out == MAX_BCD);
  assign Limit    = r_limit;
  assign w_accept = Step & ~Set & ~Busy;
  assign w_limit  = w_accept &
                    (Reverse ? Zero : AtMax);
  assign w_load   = Set |
                    (w_limit & (WRAP_MODE != 0));
  assign w_load_bcd = Set     ? w_set_bcd :
                      Reverse ? MAX_BCD   : '0;

  // Carry into each digit; bit 0 is the step itself
  always_comb begin
    w_carry    = '0;
    w_carry[0] = w_accept & ~w_limit;
    for (int k = 0; k < DIGITS; k++)
      w_carry[k+1] = w_step[k] & w_corner[k];
  end

  // Carries that become pending for the next edge
  always_comb begin
    w_carry_nxt = '0;
    for (int k = 1; k < DIGITS; k++)
      w_carry_nxt[k] = w_carry[k];
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    if (RIPPLE == 0 || k == 0) begin : g_now
      assign w_step[k] = w_carry[k];
      assign w_dir[k]  = Reverse;
    end else begin : g_rip
      assign w_step[k] = r_carry[k];
      assign w_dir[k]  = r_rev;
    end

    assign w_load_oh[k] =
      dek_bcd2oh(w_load_bcd[4*k +: 4]);

    dek_digit u_digit (
      .clk       (Clk),
      .rst_n     (Rst_n),
      .i_load    (w_load),
      .i_load_oh (w_load_oh[k]),
      .i_step    (w_step[k]),
      .i_rev     (w_dir[k]),
      .o_oh      (w_oh[k]),
      .o_corner  (w_corner[k])
    );

    assign Out[4*k +: 4]        = dek_oh2bcd(w_oh[k]);
    assign OutOneHot[10*k +: 10] = w_oh[k];
  end

  // Ripple bookkeeping and limit pulse
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_carry <= '0;
      r_rev   <= 1'b0;
      r_limit <= 1'b0;
    end else begin
      r_limit <= w_limit;
      if (Set || RIPPLE == 0) r_carry <= '0;
      else                    r_carry <= w_carry_nxt;
      if (w_accept) r_rev <= Reverse;
    end
  end

endmodule

// File: tb/tb_dekatron_counter.sv
// Bench for dekatron_counter: three configurations
// driven in parallel, checked against a numeric model.
module tb_dekatron_counter;

  localparam int MAXV = 255;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b1;
  logic        Step = 1'b0;
  logic        Reverse = 1'b0;
  logic        Set = 1'b0;
  logic [11:0] In = '0;

  logic [11:0] o_out  [3];
  logic [29:0] o_oh   [3];
  logic        o_busy [3];
  logic        o_lim  [3];
  logic        o_zero [3];
  logic        o_max  [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  dekatron_counter #(
    .DIGITS(3), .MAX_VALUE(255),
    .WRAP_MODE(1), .RIPPLE(0)
  ) u_a (
    .Clk(Clk), .Rst_n(Rst_n), .Step(Step),
    .Reverse(Reverse), .Set(Set), .In(In),
    .Out(o_out[0]), .OutOneHot(o_oh[0]),
    .Busy(o_busy[0]), .Limit(o_lim[0]),
    .Zero(o_zero[0]), .AtMax(o_max[0])
  );

  dekatron_counter #(
    .DIGITS(3), .MAX_VALUE(255),
    .WRAP_MODE(0), .RIPPLE(0)
  ) u_b (
    .Clk(Clk), .Rst_n(Rst_n), .Step(Step),
    .Reverse(Reverse), .Set(Set), .In(In),
    .Out(o_out[1]), .OutOneHot(o_oh[1]),
    .Busy(o_busy[1]), .Limit(o_lim[1]),
    .Zero(o_zero[1]), .AtMax(o_max[1])
  );

  dekatron_counter #(
    .DIGITS(3), .MAX_VALUE(255),
    .WRAP_MODE(1), .RIPPLE(1)
  ) u_c (
    .Clk(Clk), .Rst_n(Rst_n), .Step(Step),
    .Reverse(Reverse), .Set(Set), .In(In),
    .Out(o_out[2]), .OutOneHot(o_oh[2]),
    .Busy(o_busy[2]), .Limit(o_lim[2]),
    .Zero(o_zero[2]), .AtMax(o_max[2])
  );

  // Model: count as a plain integer, ripple as a
  // list of the intermediate values still to show.
  int m_wrap [3] = '{1, 0, 1};
  int m_rip  [3] = '{0, 0, 1};
  int m_cnt  [3] = '{0, 0, 0};
  int m_lim  [3] = '{0, 0, 0};
  int m_np   [3] = '{0, 0, 0};
  int m_seq  [3][3];

  function automatic int p10(int k);
    int r;
    r = 1;
    for (int j = 0; j < k; j++) r = r * 10;
    return r;
  endfunction

  function automatic int dig(int v, int k);
    return (v / p10(k)) % 10;
  endfunction

  function automatic int bcd2int(logic [11:0] b);
    int v;
    int d;
    v = 0;
    for (int k = 2; k >= 0; k--) begin
      d = int'(b[4*k +: 4]);
      if (d > 9) d = 9;
      v = v * 10 + d;
    end
    return (v > MAXV) ? MAXV : v;
  endfunction

  function automatic logic [11:0] int2bcd(int v);
    return {4'(dig(v, 2)), 4'(dig(v, 1)),
            4'(dig(v, 0))};
  endfunction

  function automatic logic [29:0] int2oh(int v);
    logic [29:0] r;
    r = '0;
    for (int k = 0; k < 3; k++)
      r[10*k + dig(v, k)] = 1'b1;
    return r;
  endfunction

  // Digits 0..j taken from nv, the rest from old
  function automatic int mix(int old, int nv, int j);
    int m;
    m = p10(j + 1);
    return (old - old % m) + (nv % m);
  endfunction

  task automatic mdl_edge(int i);
    int old;
    int nv;
    int hi;
    m_lim[i] = 0;
    if (Set) begin
      m_cnt[i] = bcd2int(In);
      m_np[i]  = 0;
    end else if (m_np[i] > 0) begin
      m_cnt[i]    = m_seq[i][0];
      m_seq[i][0] = m_seq[i][1];
      m_seq[i][1] = m_seq[i][2];
      m_np[i]     = m_np[i] - 1;
    end else if (Step) begin
      old = m_cnt[i];
      if (!Reverse && old == MAXV) begin
        m_lim[i] = 1;
        if (m_wrap[i] != 0) m_cnt[i] = 0;
      end else if (Reverse && old == 0) begin
        m_lim[i] = 1;
        if (m_wrap[i] != 0) m_cnt[i] = MAXV;
      end else begin
        nv = Reverse ? old - 1 : old + 1;
        if (m_rip[i] == 0) begin
          m_cnt[i] = nv;
        end else begin
          hi = 0;
          for (int k = 0; k < 3; k++)
            if (dig(old, k) != dig(nv, k)) hi = k;
          m_cnt[i] = mix(old, nv, 0);
          m_np[i]  = hi;
          for (int j = 1; j <= hi; j++)
            m_seq[i][j-1] = mix(old, nv, j);
        end
      end
    end
  endtask

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_cnt[i] = 0;
        m_lim[i] = 0;
        m_np[i]  = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) mdl_edge(i);
    end
  end

  // Every-cycle comparison against the model
  always @(negedge Clk) begin
    logic [15:0] act;
    logic [15:0] exp;
    for (int i = 0; i < 3; i++) begin
      act = {o_out[i], o_busy[i], o_lim[i],
             o_zero[i], o_max[i]};
      exp = {int2bcd(m_cnt[i]), m_np[i] > 0,
             m_lim[i] != 0, m_cnt[i] == 0,
             m_cnt[i] == MAXV};
      n_tests++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL model%0d out/busy/lim/zero/max got=%h want=%h t=%0t",
                 i, act, exp, $time);
      end
      n_tests++;
      if (o_oh[i] !== int2oh(m_cnt[i])) begin
        n_fail++;
        $display("FAIL model%0d onehot got=%h want=%h t=%0t",
                 i, o_oh[i], int2oh(m_cnt[i]), $time);
      end
    end
  end

  task automatic lit(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  initial begin
    #1 Rst_n = 1'b0;
    repeat (2) @(posedge Clk);
    #3 Rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      lit("rst_out", o_out[i], 0);
      lit("rst_oh", o_oh[i], 30'h0010_0401);
      lit("rst_zero", o_zero[i], 1);
      lit("rst_atmax", o_max[i], 0);
      lit("rst_busy", o_busy[i], 0);
    end

    // Count up through the limit
    Set = 1'b1; In = 12'h254;
    tick();
    Set = 1'b0;
    lit("set254", o_out[0], 12'h254);
    Step = 1'b1;
    tick();
    Step = 1'b0;
    lit("up255", o_out[0], 12'h255);
    lit("atmax255", o_max[0], 1);
    Step = 1'b1;
    tick();
    Step = 1'b0;
    lit("wrap_up", o_out[0], 12'h000);
    lit("lim_wrap_up", o_lim[0], 1);
    lit("sat_up", o_out[1], 12'h255);
    lit("lim_sat_up", o_lim[1], 1);
    lit("rip_wrap_up", o_out[2], 12'h000);
    tick();
    lit("lim_one_cycle", o_lim[0], 0);

    // Count down through zero
    Set = 1'b1; In = 12'h000;
    tick();
    Set = 1'b0;
    Step = 1'b1; Reverse = 1'b1;
    tick();
    Step = 1'b0; Reverse = 1'b0;
    lit("wrap_dn", o_out[0], 12'h255);
    lit("lim_wrap_dn", o_lim[0], 1);
    lit("sat_dn", o_out[1], 12'h000);
    lit("lim_sat_dn", o_lim[1], 1);

    // Ripple 199 -> 200, Step held during Busy
    Set = 1'b1; In = 12'h199;
    tick();
    Set = 1'b0; Step = 1'b1;
    tick();
    lit("rip_e1", o_out[2], 12'h190);
    lit("rip_busy1", o_busy[2], 1);
    lit("flat_200", o_out[0], 12'h200);
    lit("flat_busy", o_busy[0], 0);
    tick();
    lit("rip_e2", o_out[2], 12'h100);
    lit("rip_busy2", o_busy[2], 1);
    tick();
    lit("rip_e3", o_out[2], 12'h200);
    lit("rip_done", o_busy[2], 0);
    Step = 1'b0;
    tick();
    lit("rip_ignored", o_out[2], 12'h200);
    lit("model_rip", m_cnt[2], 200);

    // Clamp on load, Set beats Step
    Set = 1'b1; In = 12'h3A7;
    tick();
    Set = 1'b0;
    lit("clamp", o_out[0], 12'h255);
    lit("model_clamp", m_cnt[0], 255);
    Set = 1'b1; Step = 1'b1; In = 12'h123;
    tick();
    Set = 1'b0; Step = 1'b0;
    lit("set_step", o_out[0], 12'h123);
    lit("set_step_lim", o_lim[0], 0);
    lit("set_step_rip", o_out[2], 12'h123);

    // Asynchronous reset in the middle of a ripple
    Set = 1'b1; In = 12'h199;
    tick();
    Set = 1'b0; Step = 1'b1;
    tick();
    Step = 1'b0;
    #1 Rst_n = 1'b0;
    #1;
    lit("arst_out", o_out[2], 12'h000);
    lit("arst_busy", o_busy[2], 0);
    lit("arst_zero", o_zero[2], 1);
    @(posedge Clk);
    #3 Rst_n = 1'b1;
    tick();
    Step = 1'b1;
    tick();
    Step = 1'b0;
    lit("post_rst", o_out[2], 12'h001);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      Set     = ($urandom_range(0, 15) == 0);
      In      = 12'($urandom_range(0, 4095));
      Step    = 1'($urandom_range(0, 1));
      Reverse = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 299) == 0) begin
        #1 Rst_n = 1'b0;
        #1 Rst_n = 1'b1;
      end
      tick();
    end

    Set = 1'b0; Step = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
